rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 decoder/tri-state mux datapath between four requesters. It grants the shared output to one requester at a time. It drives the mux select lines and the one-hot tri-state enables that come from the 2:4 decoder stage. A one-cycle bus turnaround is enforced between owners so that two tri-state drivers are never enabled at once.

---
 rtl/rr_mux_arbiter.sv | 113 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 tri-state mux: one-hot enables, binary select,
// burst limiting and a mandatory idle turnaround cycle between bus owners.
module rr_mux_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic {S_IDLE, S_OWN} state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       found;
  logic [1:0] win;
  logic [1:0] idx;
  logic       others_req;

  // Rotating search starting at ptr; first set request wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign others_req = |(req & ~gnt_q);

  // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_OWN;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          ptr_d   = win + 2'd1;
        end
      end
      S_OWN: begin
        if (!req[sel_q]) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q < MAX_CNT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (others_req) begin
          // Forced release; ptr already points past the owner.
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter (MAX_BURST=4): stimulus pushes hand-computed
// {busy, sel, gnt} per cycle; a monitor pops and compares after every rising edge.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int n_vec;
  int n_bad;
  logic [1:0] last_sel;
  logic [6:0] exp_q[$];

  rr_mux_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got busy/sel/gnt=%b/%b/%b, want %b/%b/%b", name, $time,
               act[6], act[5:4], act[3:0], exp[6], exp[5:4], exp[3:0]);
    end
  endtask

  // Expected state after the coming edge; sel holds its last value while idle.
  task automatic push_exp(input logic [3:0] g);
    if (g != 4'b0000) last_sel = enc(g);
    exp_q.push_back({(g != 4'b0000), last_sel, g});
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] g);
    @(negedge clk);
    req = r;
    push_exp(g);
  endtask

  task automatic step_n(input int n, input logic [3:0] r, input logic [3:0] g);
    for (int i = 0; i < n; i++) step(r, g);
  endtask

  initial begin : monitor
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {busy, sel, gnt}, e);
      end
    end
  end

  initial begin : stim
    n_vec    = 0;
    n_bad    = 0;
    last_sel = 2'd0;
    rst_n    = 1'b0;
    req      = 4'b1111;

    // Held reset with every requester active.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", {busy, sel, gnt}, 7'b0_00_0000);
    end

    // Release: first arbitration on the first edge with rst_n high.
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(4'b0001);

    // Round robin: each owner drops req for one cycle after two grant cycles.
    step(4'b1111, 4'b0001);
    step(4'b1110, 4'b0000);
    step(4'b1111, 4'b0010);
    step(4'b1111, 4'b0010);
    step(4'b1101, 4'b0000);
    step(4'b1111, 4'b0100);
    step(4'b1111, 4'b0100);
    step(4'b1011, 4'b0000);
    step(4'b1111, 4'b1000);
    step(4'b1111, 4'b1000);
    step(4'b0111, 4'b0000);
    step(4'b1111, 4'b0001);
    step(4'b0000, 4'b0000);

    // Mid-grant reset: ptr=1, requester 2 wins, then reset drops everything at once.
    step(4'b0100, 4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check("reset_async", {busy, sel, gnt}, 7'b0_00_0000);
    last_sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 4'b0000);

    // Single requester 2 for five cycles (lone owner, counter reloads).
    step_n(5, 4'b0100, 4'b0100);
    step(4'b0000, 4'b0000);

    // Burst limit: ptr=3, so 0 wins, then 1, then 0 again, each with one idle gap.
    step_n(4, 4'b0011, 4'b0001);
    step(4'b0011, 4'b0000);
    step_n(4, 4'b0011, 4'b0010);
    step(4'b0011, 4'b0000);
    step_n(4, 4'b0011, 4'b0001);
    step(4'b0011, 4'b0000);
    step(4'b0000, 4'b0000);

    // Lone hog on requester 3: no gaps across counter reloads; leaves ptr=0.
    step_n(12, 4'b1000, 4'b1000);
    step(4'b0000, 4'b0000);

    // Wrap-around: ptr=0 so 0 wins first, then after forced release 3 wins.
    step_n(4, 4'b1001, 4'b0001);
    step(4'b1001, 4'b0000);
    step_n(2, 4'b1001, 4'b1000);
    step(4'b0000, 4'b0000);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
